// File: rtl/udp_filter_pkg.sv
// Shared header offsets, protocol constants and FSM encoding for udp_payload_filter.
// The optional IPV4_CSUM_CHECK_EN feature uses CSUM_FIRST/CSUM_LAST.
package udp_filter_pkg;

    localparam logic [5:0] ETYPE_HI   = 6'd12;
    localparam logic [5:0] ETYPE_LO   = 6'd13;
    localparam logic [5:0] IP_VER     = 6'd14;
    localparam logic [5:0] IP_PROTO   = 6'd23;
    localparam logic [5:0] UDP_DPORT  = 6'd36;
    localparam logic [5:0] UDP_LEN    = 6'd38;
    localparam logic [5:0] HDR_LAST   = 6'd41;
    localparam logic [5:0] CSUM_FIRST = 6'd14;
    localparam logic [5:0] CSUM_LAST  = 6'd33;

    localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  VER_IHL     = 8'h45;
    localparam logic [7:0]  PROTO_UDP   = 8'h11;
    localparam logic [15:0] UDP_HDR_LEN = 16'd8;

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_PAY   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Per-byte header field check; offsets without a fixed value never fail.
    function automatic logic hdr_byte_bad(input logic [5:0] idx, input logic [7:0] b,
                                          input logic [15:0] dport);
        logic bad;
        bad = 1'b0;
        case (idx)
            ETYPE_HI:          bad = (b != ETYPE_IPV4[15:8]);
            ETYPE_LO:          bad = (b != ETYPE_IPV4[7:0]);
            IP_VER:            bad = (b != VER_IHL);
            IP_PROTO:          bad = (b != PROTO_UDP);
            UDP_DPORT:         bad = (b != dport[15:8]);
            UDP_DPORT + 6'd1:  bad = (b != dport[7:0]);
            default:           bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ipv4_csum_acc.sv
// Byte-serial ones-complement 16-bit accumulator for the IPv4 header checksum.
// ok reflects the folded sum including the current low byte (valid when en lands on it).
module ipv4_csum_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic       ok
);

    logic [7:0]  hi_q;
    logic        odd_q;
    logic [15:0] sum_q;
    logic [16:0] raw;
    logic [15:0] sum_next;

    always_comb begin
        raw      = {1'b0, sum_q} + {1'b0, hi_q, data};
        // End-around carry; cannot carry again since raw <= 0x1FFFE.
        sum_next = raw[15:0] + {15'd0, raw[16]};
        ok       = (sum_next == 16'hFFFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= 8'd0;
            odd_q <= 1'b0;
            sum_q <= 16'd0;
        end else if (clear) begin
            odd_q <= 1'b0;
            sum_q <= 16'd0;
        end else if (en) begin
            if (!odd_q) begin
                hi_q  <= data;
                odd_q <= 1'b1;
            end else begin
                sum_q <= sum_next;
                odd_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/udp_payload_filter.sv
// Strips Ethernet/IPv4/UDP headers and forwards the UDP payload of frames for DST_PORT.
// Define IPV4_CSUM_CHECK_EN to also reject frames with a bad IPv4 header checksum.
module udp_payload_filter
    import udp_filter_pkg::*;
#(
    parameter logic [15:0] DST_PORT    = 16'd5000,
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             axis_aclk,
    input  logic             axis_aresetn,
    input  logic [7:0]       s00_axis_tdata,
    input  logic             s00_axis_tvalid,
    output logic             s00_axis_tready,
    input  logic             s00_axis_tlast,
    output logic [7:0]       m00_axis_tdata,
    output logic             m00_axis_tvalid,
    input  logic             m00_axis_tready,
    output logic             m00_axis_tlast,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_drop
);

    state_t            state_q, state_d;
    logic [5:0]        hdr_cnt_q, hdr_cnt_d;
    logic              fail_q, fail_d;
    logic [15:0]       udp_len_q, udp_len_d;
    logic [15:0]       rem_q, rem_d;
    logic [7:0]        out_data_q;
    logic              out_valid_q, out_last_q;
    logic [CNT_W-1:0]  ok_cnt_q, drop_cnt_q;
    logic              inc_ok, inc_drop;
    logic              in_fire, pay_fire, pay_last;
    logic              hdr_bad, fail_now, len_ok, csum_fail;

    assign s00_axis_tready = (state_q == S_PAY) ? (!out_valid_q || m00_axis_tready) : 1'b1;
    assign in_fire         = s00_axis_tvalid && s00_axis_tready;
    assign pay_fire        = in_fire && (state_q == S_PAY);
    assign pay_last        = (rem_q == 16'd1) || s00_axis_tlast;

    assign m00_axis_tdata  = out_data_q;
    assign m00_axis_tvalid = out_valid_q;
    assign m00_axis_tlast  = out_last_q;
    assign frames_ok       = ok_cnt_q;
    assign frames_drop     = drop_cnt_q;

`ifdef IPV4_CSUM_CHECK_EN
    logic csum_en, csum_clear, csum_ok;

    assign csum_clear = in_fire && (state_q == S_HDR) && (hdr_cnt_q == 6'd0);
    assign csum_en    = in_fire && (state_q == S_HDR) &&
                        (hdr_cnt_q >= CSUM_FIRST) && (hdr_cnt_q <= CSUM_LAST);
    assign csum_fail  = csum_en && (hdr_cnt_q == CSUM_LAST) && !csum_ok;

    ipv4_csum_acc u_csum (
        .clk   (axis_aclk),
        .rst_n (axis_aresetn),
        .clear (csum_clear),
        .en    (csum_en),
        .data  (s00_axis_tdata),
        .ok    (csum_ok)
    );
`else
    assign csum_fail = 1'b0;
`endif

    assign hdr_bad  = hdr_byte_bad(hdr_cnt_q, s00_axis_tdata, DST_PORT) || csum_fail;
    assign fail_now = fail_q || hdr_bad;
    assign len_ok   = (udp_len_q >= 16'd9) && (32'(udp_len_q) <= MAX_PAYLOAD + 32'd8);

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        fail_d    = fail_q;
        udp_len_d = udp_len_q;
        rem_d     = rem_q;
        inc_ok    = 1'b0;
        inc_drop  = 1'b0;
        case (state_q)
            S_HDR: begin
                if (in_fire) begin
                    hdr_cnt_d = hdr_cnt_q + 6'd1;
                    fail_d    = fail_now;
                    if (hdr_cnt_q == UDP_LEN)        udp_len_d = {s00_axis_tdata, udp_len_q[7:0]};
                    if (hdr_cnt_q == UDP_LEN + 6'd1) udp_len_d = {udp_len_q[15:8], s00_axis_tdata};
                    if (hdr_cnt_q == HDR_LAST) begin
                        hdr_cnt_d = 6'd0;
                        fail_d    = 1'b0;
                        // A valid header ending the frame carries no payload; count it as a drop.
                        if (!fail_now && len_ok && !s00_axis_tlast) begin
                            rem_d   = udp_len_q - UDP_HDR_LEN;
                            state_d = S_PAY;
                        end else begin
                            inc_drop = 1'b1;
                            state_d  = s00_axis_tlast ? S_HDR : S_DRAIN;
                        end
                    end else if (s00_axis_tlast) begin
                        inc_drop  = 1'b1;
                        hdr_cnt_d = 6'd0;
                        fail_d    = 1'b0;
                    end
                end
            end
            S_PAY: begin
                if (in_fire) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        inc_ok  = 1'b1;
                        state_d = s00_axis_tlast ? S_HDR : S_DRAIN;
                    end else if (s00_axis_tlast) begin
                        inc_drop = 1'b1;
                        state_d  = S_HDR;
                    end
                end
            end
            S_DRAIN: begin
                if (in_fire && s00_axis_tlast) begin
                    hdr_cnt_d = 6'd0;
                    state_d   = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q   <= S_HDR;
            hdr_cnt_q <= 6'd0;
            fail_q    <= 1'b0;
            udp_len_q <= 16'd0;
            rem_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            fail_q    <= fail_d;
            udp_len_q <= udp_len_d;
            rem_q     <= rem_d;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (pay_fire) begin
            out_data_q  <= s00_axis_tdata;
            out_valid_q <= 1'b1;
            out_last_q  <= pay_last;
        end else if (m00_axis_tready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (inc_ok && (ok_cnt_q != {CNT_W{1'b1}}))     ok_cnt_q   <= ok_cnt_q + CNT_W'(1);
            if (inc_drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_udp_payload_filter.sv
// Randomized self-checking bench for udp_payload_filter against a frame-level reference model.
module tb_udp_payload_filter;

    localparam logic [15:0] DST  = 16'd5000;
    localparam int          MAXP = 1472;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b1;
    logic [15:0] f_ok, f_drop;

    int checks = 0;
    int errors = 0;
    int exp_ok = 0;
    int exp_drop = 0;
    int stall_err = 0;
    int rdy_err = 0;
    int rdy_mode = 0;
    logic gaps = 1'b0;

    logic [7:0] frame[$];
    logic [8:0] exp_q[$];
    logic [8:0] recv[$];

    always #5 clk = ~clk;

    udp_payload_filter #(
        .DST_PORT    (DST),
        .MAX_PAYLOAD (MAXP),
        .CNT_W       (16)
    ) dut (
        .axis_aclk       (clk),
        .axis_aresetn    (rst_n),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tlast  (s_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tlast  (m_tlast),
        .frames_ok       (f_ok),
        .frames_drop     (f_drop)
    );

    always @(negedge clk) begin
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: records transfers and flags handshake-rule violations.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat = 9'd0;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} != prev_beat)) stall_err++;
            if (!s_tready && !(m_tvalid && !m_tready)) rdy_err++;
            if (m_tvalid && m_tready) recv.push_back({m_tlast, m_tdata});
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] ip_sum();
        int unsigned s = 0;
        for (int i = 14; i < 34; i += 2) begin
            s = s + {16'd0, frame[i], frame[i+1]};
            s = (s & 32'hFFFF) + (s >> 16);
        end
        return s[15:0];
    endfunction

    task automatic build(input logic [15:0] dport, input logic [15:0] etype, input logic [7:0] ver,
                         input logic [7:0] proto, input logic [15:0] ulen, input int nafter);
        logic [15:0] c;
        frame.delete();
        for (int i = 0; i < 42 + nafter; i++) frame.push_back(8'($urandom));
        frame[12] = etype[15:8];
        frame[13] = etype[7:0];
        frame[14] = ver;
        frame[15] = 8'h00;
        {frame[16], frame[17]} = ulen + 16'd20;
        frame[22] = 8'd64;
        frame[23] = proto;
        {frame[36], frame[37]} = dport;
        {frame[38], frame[39]} = ulen;
        frame[40] = 8'h00;
        frame[41] = 8'h00;
        frame[24] = 8'h00;
        frame[25] = 8'h00;
        c = ~ip_sum();
        frame[24] = c[15:8];
        frame[25] = c[7:0];
    endtask

    // Reference model: what the filter should emit for the frame, plus counter totals.
    task automatic model();
        int n, len, plen, avail, k;
        logic bad;
        n = frame.size();
        exp_q.delete();
        if (n < 42) begin
            exp_drop++;
            return;
        end
        bad = (frame[12] != 8'h08) || (frame[13] != 8'h00) || (frame[14] != 8'h45) ||
              (frame[23] != 8'h11) || ({frame[36], frame[37]} != DST);
`ifdef IPV4_CSUM_CHECK_EN
        if (ip_sum() != 16'hFFFF) bad = 1'b1;
`endif
        len = int'({frame[38], frame[39]});
        if (bad || len < 9 || len > MAXP + 8 || n == 42) begin
            exp_drop++;
            return;
        end
        plen  = len - 8;
        avail = n - 42;
        k     = (avail < plen) ? avail : plen;
        for (int j = 0; j < k; j++) exp_q.push_back({(j == k - 1), frame[42 + j]});
        if (avail >= plen) exp_ok++;
        else exp_drop++;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = l;
        #1;
        while (!s_tready && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $error("FAIL s_tready_timeout: observed 0 expected 1");
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input int count);
        for (int i = 0; i < count; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                s_tvalid = 1'b0;
            end
            send_byte(frame[i], (i == frame.size() - 1));
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (m_tvalid && n < 2000);
        if (n >= 2000) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed tvalid 1 expected 0");
        end
        @(negedge clk);
        #3;
    endtask

    task automatic run_frame(input string tag);
        int m;
        model();
        recv.delete();
        send_frame(frame.size());
        drain();
        check({tag, "_len"}, recv.size(), exp_q.size());
        m = (recv.size() < exp_q.size()) ? recv.size() : exp_q.size();
        for (int j = 0; j < m; j++) check({tag, "_beat"}, {23'd0, recv[j]}, {23'd0, exp_q[j]});
        check({tag, "_ok"}, {16'd0, f_ok}, exp_ok);
        check({tag, "_drop"}, {16'd0, f_drop}, exp_drop);
        check({tag, "_stall"}, stall_err, 0);
        check({tag, "_rdy"}, rdy_err, 0);
    endtask

    task automatic spec_frame(input logic [15:0] dport, input logic [15:0] etype);
        logic [7:0] pl[9];
        pl = '{8'h01, 8'h00, 8'h64, 8'h80, 8'h00, 8'h00, 8'h00, 8'h03, 8'hE8};
        build(dport, etype, 8'h45, 8'h11, 16'h0011, 18);
        for (int j = 0; j < 9; j++) frame[42 + j] = pl[j];
        for (int j = 51; j < 60; j++) frame[j] = 8'h00;
    endtask

    initial begin
        int kind, plen, pad;
        logic [15:0] ulen;
        rst_n    = 1'b0;
        s_tdata  = 8'd0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #12;
        check("rst_tvalid", {31'd0, m_tvalid}, 0);
        check("rst_tlast", {31'd0, m_tlast}, 0);
        check("rst_tdata", {24'd0, m_tdata}, 0);
        check("rst_ok", {16'd0, f_ok}, 0);
        check("rst_drop", {16'd0, f_drop}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_s_tready", {31'd0, s_tready}, 1);

        spec_frame(16'h1388, 16'h0800);
        run_frame("good");
        check("good_last_beat", {23'd0, (recv.size() == 9) ? recv[8] : 9'd0}, 32'h1E8);

        spec_frame(16'h1389, 16'h0800);
        run_frame("wrong_port");
        spec_frame(16'h1388, 16'h86DD);
        run_frame("bad_etype");
        spec_frame(16'h1388, 16'h0800);
        frame = frame[0:30];
        run_frame("short");
        spec_frame(16'h1388, 16'h0800);
        run_frame("good_after");

        rdy_mode = 1;
        spec_frame(16'h1388, 16'h0800);
        run_frame("backpressure");
        rdy_mode = 0;

        spec_frame(16'h1388, 16'h0800);
        frame = frame[0:46];
        run_frame("truncated");

        spec_frame(16'h1388, 16'h0800);
        frame[24] = frame[24] ^ 8'hFF;
        run_frame("bad_csum");

        build(DST, 16'h0800, 8'h45, 8'h11, 16'd9, 18);
        run_frame("len_min");
        build(DST, 16'h0800, 8'h45, 8'h11, 16'd8, 18);
        run_frame("len_8");
        build(DST, 16'h0800, 8'h45, 8'h11, 16'(MAXP + 8), MAXP + 4);
        run_frame("len_max");
        build(DST, 16'h0800, 8'h45, 8'h11, 16'(MAXP + 9), 18);
        run_frame("len_over");
        build(DST, 16'h0800, 8'h45, 8'h11, 16'd20, 0);
        run_frame("hdr_only");

        rdy_mode = 2;
        gaps     = 1'b1;
        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(0, 5);
            plen = $urandom_range(1, 24);
            pad  = ((42 + plen < 60) ? 60 - 42 - plen : 0) + ($urandom_range(0, 1) ? 4 : 0);
            ulen = 16'(plen + 8);
            case (kind)
                1: build(16'(DST + 16'd1), 16'h0800, 8'h45, 8'h11, ulen, plen + pad);
                2: build(DST, 16'h0800, 8'h46, 8'h11, ulen, plen + pad);
                3: begin
                    build(DST, 16'h0800, 8'h45, 8'h11, ulen, plen + pad);
                    frame = frame[0:$urandom_range(0, 40)];
                end
                4: begin
                    build(DST, 16'h0800, 8'h45, 8'h11, ulen, plen + pad);
                    frame = frame[0:42 + $urandom_range(0, plen - 1)];
                end
                5: build(DST, 16'h0800, 8'h45, 8'h06, ulen, plen + pad);
                default: build(DST, 16'h0800, 8'h45, 8'h11, ulen, plen + pad);
            endcase
            run_frame("random");
        end

        // Reset in the middle of a payload must empty the output without a tlast.
        rdy_mode = 0;
        gaps     = 1'b0;
        build(DST, 16'h0800, 8'h45, 8'h11, 16'd28, 24);
        send_frame(50);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", {31'd0, m_tvalid}, 0);
        check("midrst_tlast", {31'd0, m_tlast}, 0);
        check("midrst_ok", {16'd0, f_ok}, 0);
        check("midrst_drop", {16'd0, f_drop}, 0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        exp_ok   = 0;
        exp_drop = 0;
        spec_frame(16'h1388, 16'h0800);
        run_frame("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
